td_alu_sequencer: RTL and testbench

- Sequences one time-domain ALU (TD-ALU) operation at a time on behalf of a single binary requester.
- Accepts a binary opcode and two operands over a valid/ready handshake, then drives the ALU op-select lines and pulse-width-encodes the operands onto td_a/td_b.
- Measures the ALU output td_y through a synchronizer and returns a binary result over a valid/ready response channel.
- Sits between the digital control domain and the TD-ALU macro.

---
 rtl/td_alu_sequencer_if.sv | 41 ++++
 rtl/td_alu_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_td_alu_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/td_alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// td_alu_sequencer_if
//   Request/response bundle between a binary requester and td_alu_sequencer.
//
//   Request channel (valid/ready):
//     req_valid  requester -> sequencer  request valid
//     req_ready  sequencer -> requester  request ready (sequencer idle)
//     req_op     requester -> sequencer  3-bit opcode
//     req_a      requester -> sequencer  operand a, WIDTH bits
//     req_b      requester -> sequencer  operand b, WIDTH bits
//   Response channel (valid/ready):
//     resp_valid sequencer -> requester  response valid
//     resp_ready requester -> sequencer  response accepted
//     resp_data  sequencer -> requester  result, WIDTH bits
//     resp_err   sequencer -> requester  reserved opcode or measurement overflow
//
//   master: the requester side.  slave: the sequencer side.
// -----------------------------------------------------------------------------
interface td_alu_sequencer_if #(
   parameter int WIDTH = 4
);
   logic             req_valid;
   logic             req_ready;
   logic [2:0]       req_op;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_data;
   logic             resp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_data, resp_err
   );
endinterface

// File: rtl/td_alu_sequencer.sv
// -----------------------------------------------------------------------------
// td_alu_sequencer
//   Runs one time-domain ALU operation at a time for a single binary
//   requester. A request (opcode, a, b) is captured, the ALU op-select lines
//   are driven, and each operand is pulse-width encoded onto td_a/td_b over a
//   window of 2**WIDTH cycles (value v = v cycles high). The ALU output td_y
//   is synchronized and its high samples are counted to recover the binary
//   result, which is returned on the response channel.
//
//   Ports:
//     clk        system clock
//     rst        synchronous, active-high reset (aborts any transaction)
//     bus        request/response channels (slave side of the interface)
//     busy       high whenever the sequencer is not idle
//     op_0..op_2 ALU op select, op_2 is the MSB
//     td_a, td_b pulse-encoded operands to the ALU
//     td_y       ALU output, asynchronous to clk
//
//   Sequence: IDLE -> SETUP (SETTLE cycles) -> DRIVE (2**WIDTH cycles)
//             -> DRAIN (2 cycles) -> RESP (until resp_ready) -> IDLE.
//   All outputs are registered.
// -----------------------------------------------------------------------------
module td_alu_sequencer #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 2
) (
   input  logic                clk,
   input  logic                rst,
   td_alu_sequencer_if.slave   bus,
   output logic                busy,
   output logic                op_0,
   output logic                op_1,
   output logic                op_2,
   output logic                td_a,
   output logic                td_b,
   input  logic                td_y
);

   localparam int WINDOW = 2 ** WIDTH;
   // Phase counter must hold both the settle count and the drive window.
   localparam int TMAX   = (SETTLE > WINDOW) ? SETTLE : WINDOW;
   localparam int TW     = $clog2(TMAX + 1);
   // Sample counter must reach WINDOW to detect a stuck-high td_y.
   localparam int CW     = WIDTH + 1;

   localparam logic [2:0] OP_CMP = 3'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_DRIVE,
      S_DRAIN,
      S_RESP
   } state_t;

   state_t           state_reg;
   logic [2:0]       op_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [TW-1:0]    t_reg;
   logic [CW-1:0]    cnt_reg;
   logic             sync1_reg;
   logic             sync2_reg;

   logic             req_ready_reg;
   logic             resp_valid_reg;
   logic [WIDTH-1:0] resp_data_reg;
   logic             resp_err_reg;
   logic             busy_reg;
   logic [2:0]       op_out_reg;
   logic             td_a_reg;
   logic             td_b_reg;

   logic [TW-1:0]    t_inc;
   logic [TW-1:0]    a_ext;
   logic [TW-1:0]    b_ext;
   logic [CW-1:0]    sync_ext;
   logic [CW-1:0]    cnt_plus;
   logic             op_reserved;

   assign t_inc       = t_reg + TW'(1);
   assign a_ext       = TW'(a_reg);
   assign b_ext       = TW'(b_reg);
   assign sync_ext    = CW'(sync2_reg);
   assign cnt_plus    = cnt_reg + sync_ext;
   assign op_reserved = op_reg[2] & op_reg[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         op_reg         <= '0;
         a_reg          <= '0;
         b_reg          <= '0;
         t_reg          <= '0;
         cnt_reg        <= '0;
         sync1_reg      <= 1'b0;
         sync2_reg      <= 1'b0;
         req_ready_reg  <= 1'b1;
         resp_valid_reg <= 1'b0;
         resp_data_reg  <= '0;
         resp_err_reg   <= 1'b0;
         busy_reg       <= 1'b0;
         op_out_reg     <= '0;
         td_a_reg       <= 1'b0;
         td_b_reg       <= 1'b0;
      end else begin
         // Two-flop synchronizer for the asynchronous ALU output.
         sync1_reg <= td_y;
         sync2_reg <= sync1_reg;

         case (state_reg)
            S_IDLE: begin
               if (bus.req_valid && req_ready_reg) begin
                  op_reg        <= bus.req_op;
                  a_reg         <= bus.req_a;
                  b_reg         <= bus.req_b;
                  op_out_reg    <= bus.req_op;
                  t_reg         <= '0;
                  cnt_reg       <= '0;
                  req_ready_reg <= 1'b0;
                  busy_reg      <= 1'b1;
                  state_reg     <= S_SETUP;
               end
            end

            S_SETUP: begin
               if (op_reserved) begin
                  // Reserved opcodes spend a single SETUP cycle (nothing is
                  // ever driven on td_a/td_b) and answer with an error.
                  op_out_reg     <= '0;
                  resp_valid_reg <= 1'b1;
                  resp_data_reg  <= '0;
                  resp_err_reg   <= 1'b1;
                  state_reg      <= S_RESP;
               end else if (t_reg == TW'(SETTLE - 1)) begin
                  // First drive cycle is t=0: high iff operand is non-zero.
                  t_reg     <= '0;
                  td_a_reg  <= (a_ext != '0);
                  td_b_reg  <= (b_ext != '0);
                  state_reg <= S_DRIVE;
               end else begin
                  t_reg <= t_inc;
               end
            end

            S_DRIVE: begin
               // The synchronizer adds two cycles of delay, so the sample
               // seen during drive cycle t belongs to window position t-2.
               if (t_reg >= TW'(2)) begin
                  cnt_reg <= cnt_plus;
               end
               if (t_reg == TW'(WINDOW - 1)) begin
                  t_reg     <= '0;
                  td_a_reg  <= 1'b0;
                  td_b_reg  <= 1'b0;
                  state_reg <= S_DRAIN;
               end else begin
                  t_reg    <= t_inc;
                  td_a_reg <= (t_inc < a_ext);
                  td_b_reg <= (t_inc < b_ext);
               end
            end

            S_DRAIN: begin
               // The two drain cycles carry the last two window positions
               // out of the synchronizer.
               if (t_reg == '0) begin
                  cnt_reg <= cnt_plus;
                  t_reg   <= TW'(1);
               end else begin
                  op_out_reg     <= '0;
                  resp_valid_reg <= 1'b1;
                  if (op_reg == OP_CMP) begin
                     resp_data_reg <= {{(WIDTH-1){1'b0}}, sync2_reg};
                     resp_err_reg  <= 1'b0;
                  end else if (cnt_plus[WIDTH]) begin
                     // td_y high for the whole window: saturate and flag.
                     resp_data_reg <= '1;
                     resp_err_reg  <= 1'b1;
                  end else begin
                     resp_data_reg <= cnt_plus[WIDTH-1:0];
                     resp_err_reg  <= 1'b0;
                  end
                  state_reg <= S_RESP;
               end
            end

            S_RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_reg <= 1'b0;
                  resp_data_reg  <= '0;
                  resp_err_reg   <= 1'b0;
                  busy_reg       <= 1'b0;
                  req_ready_reg  <= 1'b1;
                  state_reg      <= S_IDLE;
               end
            end

            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready_reg;
   assign bus.resp_valid = resp_valid_reg;
   assign bus.resp_data  = resp_data_reg;
   assign bus.resp_err   = resp_err_reg;
   assign busy           = busy_reg;
   assign op_0           = op_out_reg[0];
   assign op_1           = op_out_reg[1];
   assign op_2           = op_out_reg[2];
   assign td_a           = td_a_reg;
   assign td_b           = td_b_reg;

endmodule

// File: tb/tb_td_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_td_alu_sequencer
//   Bench for td_alu_sequencer with a behavioural TD-ALU model driving td_y.
//   Expected responses are queued when a request is driven and compared when
//   the response handshake happens.
// -----------------------------------------------------------------------------
module tb_td_alu_sequencer;

   localparam int WIDTH  = 4;
   localparam int SETTLE = 2;
   localparam int LAT    = SETTLE + 2 ** WIDTH + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy, op_0, op_1, op_2, td_a, td_b, td_y;
   bit   force_high = 1'b0;
   logic alu_y;
   logic [2:0] op_lines;

   td_alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

   td_alu_sequencer #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy),
      .op_0 (op_0),
      .op_1 (op_1),
      .op_2 (op_2),
      .td_a (td_a),
      .td_b (td_b),
      .td_y (td_y)
   );

   always #5 clk = ~clk;

   assign op_lines = {op_2, op_1, op_0};

   // Ideal time-domain ALU: max = OR, min = AND, |a-b| = XOR of the pulses.
   always_comb begin
      alu_y = 1'b0;
      case (op_lines)
         3'd0:    alu_y = td_a | td_b;
         3'd1:    alu_y = td_a & td_b;
         3'd2:    alu_y = td_a & ~td_b;
         3'd3:    alu_y = td_a ^ td_b;
         3'd4:    alu_y = td_a;
         3'd5:    alu_y = td_b;
         default: alu_y = 1'b0;
      endcase
   end
   assign td_y = force_high | alu_y;

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [2:0]  op;
      int unsigned data;
      int unsigned err;
      int unsigned lat;
   } exp_t;

   exp_t exp_q[$];

   // ---------------- monitor / scoreboard ----------------
   int unsigned cyc       = 0;
   int unsigned acc_edge  = 0;
   int unsigned rise_edge = 0;
   int unsigned hs_edge   = 0;
   int unsigned resp_cnt  = 0;
   logic [2:0]  cur_op    = 3'd0;
   bit          op_ok     = 1'b1;
   bit          td_seen   = 1'b0;
   bit          prev_rv   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_rv = 1'b0;
      end else begin
         if (bus.req_valid && bus.req_ready) begin
            acc_edge = cyc + 1;
            cur_op   = bus.req_op;
            op_ok    = 1'b1;
            td_seen  = 1'b0;
         end
         if (busy && !bus.resp_valid) begin
            if (op_lines != cur_op) op_ok = 1'b0;
         end else if (op_lines != 3'd0) begin
            op_ok = 1'b0;
         end
         if (td_a || td_b) td_seen = 1'b1;
         if (bus.resp_valid && !prev_rv) rise_edge = cyc;
         if (bus.resp_valid && bus.resp_ready) begin
            hs_edge = cyc + 1;
            check_eq("resp_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               $display("txn op=%0d data=%0d err=%0d lat=%0d", e.op, bus.resp_data,
                        bus.resp_err, rise_edge - acc_edge);
               check_eq("resp_data", bus.resp_data, e.data);
               check_eq("resp_err", bus.resp_err, e.err);
               check_eq("latency", rise_edge - acc_edge, e.lat);
               check_eq("op_lines", op_ok, 1);
               if (e.op[2] && e.op[1]) check_eq("no_td_toggle", td_seen, 0);
               resp_cnt++;
            end
         end
         prev_rv = bus.resp_valid;
      end
   end

   // ---------------- driver ----------------
   task automatic issue(input logic [2:0] op, input int unsigned a, input int unsigned b,
                        input int unsigned ed, input int unsigned ee);
      exp_t e;
      bit   ok = 1'b0;
      e.op   = op;
      e.data = ed;
      e.err  = ee;
      e.lat  = (op >= 3'd6) ? 1 : LAT;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      bus.req_op    = op;
      bus.req_a     = a[WIDTH-1:0];
      bus.req_b     = b[WIDTH-1:0];
      bus.req_valid = 1'b1;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("accept", ok, 1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic wait_resp(input int unsigned n);
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (resp_cnt >= n) break;
      end
      @(negedge clk);
      check_eq("resp_count", resp_cnt, n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cycles=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      bit stable;
      int unsigned n = 0;

      bus.req_valid  = 1'b0;
      bus.req_op     = 3'd0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.resp_ready = 1'b1;

      // Reset values
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("rst_req_ready", bus.req_ready, 1);
      check_eq("rst_resp_valid", bus.resp_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_td", {td_a, td_b}, 0);
      check_eq("rst_op", op_lines, 0);
      check_eq("rst_resp_data", bus.resp_data, 0);

      // Main function
      issue(3'd0, 5, 9, 9, 0);   wait_resp(++n);
      issue(3'd1, 5, 9, 5, 0);   wait_resp(++n);
      issue(3'd3, 12, 3, 9, 0);  wait_resp(++n);
      issue(3'd4, 7, 2, 7, 0);   wait_resp(++n);
      issue(3'd5, 6, 0, 0, 0);   wait_resp(++n);

      // Boundaries
      issue(3'd0, 15, 15, 15, 0); wait_resp(++n);
      issue(3'd1, 0, 0, 0, 0);    wait_resp(++n);
      force_high = 1'b1;
      issue(3'd0, 3, 4, 15, 1);   wait_resp(++n);
      force_high = 1'b0;

      // Reserved opcodes and compare
      issue(3'd6, 5, 9, 0, 1);    wait_resp(++n);
      issue(3'd7, 15, 15, 0, 1);  wait_resp(++n);
      force_high = 1'b1;
      issue(3'd2, 9, 4, 1, 0);    wait_resp(++n);
      force_high = 1'b0;
      issue(3'd2, 9, 4, 0, 0);    wait_resp(++n);

      // Backpressure, with a second request held during busy
      bus.resp_ready = 1'b0;
      issue(3'd0, 3, 10, 10, 0);
      begin
         exp_t eb;
         eb.op = 3'd1; eb.data = 3; eb.err = 0; eb.lat = LAT;
         exp_q.push_back(eb);
         bus.req_op    = 3'd1;
         bus.req_a     = 4'd3;
         bus.req_b     = 4'd10;
         bus.req_valid = 1'b1;
      end
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.resp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("bp_resp_valid", ok, 1);
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (!(bus.resp_valid && bus.resp_data == 4'd10 && !bus.resp_err && !bus.req_ready))
            stable = 1'b0;
      end
      check_eq("bp_stable", stable, 1);
      @(posedge clk);
      #1 bus.resp_ready = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("bp_second_accept", ok, 1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      check_eq("accept_after_hs", acc_edge, hs_edge + 1);
      n += 2;
      wait_resp(n);

      // Reset abort in the middle of DRIVE (t=6)
      @(posedge clk);
      #1;
      bus.req_op    = 3'd3;
      bus.req_a     = 4'd9;
      bus.req_b     = 4'd2;
      bus.req_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("abort_accept", ok, 1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check_eq("abort_pre_td", {td_a, td_b}, 2'b10);
      check_eq("abort_pre_op", op_lines, 3);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_req_ready", bus.req_ready, 1);
      check_eq("abort_td", {td_a, td_b}, 0);
      check_eq("abort_op", op_lines, 0);
      stable = 1'b1;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (bus.resp_valid) stable = 1'b0;
      end
      check_eq("abort_no_resp", stable, 1);
      check_eq("abort_resp_count", resp_cnt, n);

      issue(3'd0, 2, 3, 3, 0);   wait_resp(++n);

      check_eq("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
